// File: rtl/cic_decim_tail_pkg.sv
// cic_decim_tail_pkg: shared defaults and helpers
// for the CIC decimator tail (downsampler + combs).
package cic_decim_tail_pkg;

  localparam int DEF_DW      = 32;
  localparam int DEF_RATE_DW = 32;
  localparam int DEF_CIC_R   = 10;
  localparam int DEF_CIC_N   = 7;
  localparam int DEF_CIC_M   = 1;

  // A programmed rate of zero behaves as rate one.
  function automatic logic [63:0] eff_rate(
    input logic [63:0] rate
  );
    return (rate == 64'd0) ? 64'd1 : rate;
  endfunction

endpackage

// File: rtl/cic_decim_tail_comb.sv
// cic_comb_stage: one CIC differentiator,
// y = x - x[n-M], advancing only on input strobes.
module cic_comb_stage
  import cic_decim_tail_pkg::*;
#(
  parameter int SAMP_WIDTH = DEF_DW,
  parameter int CIC_M      = DEF_CIC_M
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [SAMP_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [SAMP_WIDTH-1:0] out_data,
  output logic                  out_valid
);

  logic [SAMP_WIDTH-1:0] dly_q [CIC_M];
  logic [SAMP_WIDTH-1:0] dly_d [CIC_M];
  logic [SAMP_WIDTH-1:0] out_q, out_d;
  logic                  valid_q, valid_d;

  // Difference against the oldest tap; shift line on strobe.
  always_comb begin
    dly_d   = dly_q;
    out_d   = out_q;
    valid_d = in_valid;
    if (in_valid) begin
      out_d    = in_data - dly_q[CIC_M-1];
      dly_d[0] = in_data;
      for (int i = 1; i < CIC_M; i++) begin
        dly_d[i] = dly_q[i-1];
      end
    end
  end

  // Stage registers; reset clears all history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CIC_M; i++) begin
        dly_q[i] <= '0;
      end
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      dly_q   <= dly_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = out_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/cic_decim_tail.sv
// cic_decim_tail: decimate-by-R then CIC_N combs,
// one registered output per R accepted samples.
module cic_decim_tail
  import cic_decim_tail_pkg::*;
#(
  parameter int DW            = DEF_DW,
  parameter int RATE_DW       = DEF_RATE_DW,
  parameter int CIC_R         = DEF_CIC_R,
  parameter int CIC_N         = DEF_CIC_N,
  parameter int CIC_M         = DEF_CIC_M,
  parameter int VARIABLE_RATE = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DW-1:0]      s_axis_in_tdata,
  input  logic               s_axis_in_tvalid,
  input  logic [RATE_DW-1:0] s_axis_rate_tdata,
  input  logic               s_axis_rate_tvalid,
  output logic [DW-1:0]      m_axis_out_tdata,
  output logic               m_axis_out_tvalid
);

  localparam logic [RATE_DW-1:0] ONE = RATE_DW'(1);

  logic [RATE_DW-1:0] rate_eff;
  logic               rate_load;
  logic [RATE_DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]      ds_data_q, ds_data_d;
  logic               ds_valid_q, ds_valid_d;
  logic [DW-1:0]      stg_data [CIC_N+1];
  logic [CIC_N:0]     stg_valid;

  if (VARIABLE_RATE != 0) begin : g_var_rate
    logic [RATE_DW-1:0] rate_q, rate_d;

    // A load applies to the sample in the same cycle.
    always_comb begin
      rate_d = rate_q;
      if (s_axis_rate_tvalid) begin
        rate_d = s_axis_rate_tdata;
      end
    end

    // Programmable rate register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rate_q <= RATE_DW'(CIC_R);
      end else begin
        rate_q <= rate_d;
      end
    end

    assign rate_load = s_axis_rate_tvalid;
    assign rate_eff  = RATE_DW'(eff_rate(64'(rate_d)));
  end else begin : g_fix_rate
    logic unused_rate;
    assign unused_rate =
      ^{s_axis_rate_tvalid, s_axis_rate_tdata};
    assign rate_load = 1'b0;
    assign rate_eff  = RATE_DW'(eff_rate(64'(CIC_R)));
  end

  // Phase counter; a rate load restarts the period.
  always_comb begin
    cnt_d      = cnt_q;
    ds_data_d  = ds_data_q;
    ds_valid_d = 1'b0;
    if (rate_load) begin
      cnt_d = '0;
      if (s_axis_in_tvalid) begin
        if (rate_eff == ONE) begin
          ds_data_d  = s_axis_in_tdata;
          ds_valid_d = 1'b1;
        end else begin
          cnt_d = ONE;
        end
      end
    end else if (s_axis_in_tvalid) begin
      if (cnt_q == rate_eff - ONE) begin
        ds_data_d  = s_axis_in_tdata;
        ds_valid_d = 1'b1;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // Downsampler registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      ds_data_q  <= '0;
      ds_valid_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ds_data_q  <= ds_data_d;
      ds_valid_q <= ds_valid_d;
    end
  end

  assign stg_data[0]  = ds_data_q;
  assign stg_valid[0] = ds_valid_q;

  for (genvar k = 0; k < CIC_N; k++) begin : g_comb
    cic_comb_stage #(
      .SAMP_WIDTH(DW),
      .CIC_M     (CIC_M)
    ) u_comb (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_data  (stg_data[k]),
      .in_valid (stg_valid[k]),
      .out_data (stg_data[k+1]),
      .out_valid(stg_valid[k+1])
    );
  end

  assign m_axis_out_tdata  = stg_data[CIC_N];
  assign m_axis_out_tvalid = stg_valid[CIC_N];

endmodule

// File: tb/tb_cic_decim_tail.sv
// tb_cic_decim_tail: directed tables, hand sequences
// and a randomized run against a difference-equation model.
module tb_cic_decim_tail;

  localparam int RN = 7;
  localparam int RM = 1;

  typedef struct {
    int          cyc;
    logic [31:0] d;
  } ev_t;

  typedef struct {
    bit         use_d;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [31:0] a_din, a_rdat, a_dout;
  logic        a_vld, a_rvld, a_ovld;
  logic [31:0] b_din, b_rdat, b_dout;
  logic        b_vld, b_rvld, b_ovld;
  logic [7:0]  c_din, c_rdat, c_dout;
  logic        c_vld, c_rvld, c_ovld;
  logic [7:0]  d_din, d_rdat, d_dout;
  logic        d_vld, d_rvld, d_ovld;
  logic [31:0] r_din, r_rdat, r_dout;
  logic        r_vld, r_rvld, r_ovld;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int m_rate   = 10;
  int m_seen   = 0;
  int r_outs   = 0;

  ev_t         qa[$];
  ev_t         qb[$];
  ev_t         exp_r[$];
  logic [31:0] hist[$];
  vec_t        tbl[7];

  always #5 clk = ~clk;

  cic_decim_tail #(
    .DW(32), .RATE_DW(32), .CIC_R(4),
    .CIC_N(1), .CIC_M(1), .VARIABLE_RATE(0)
  ) dut_a (
    .clk(clk), .reset_n(rst_n),
    .s_axis_in_tdata(a_din), .s_axis_in_tvalid(a_vld),
    .s_axis_rate_tdata(a_rdat),
    .s_axis_rate_tvalid(a_rvld),
    .m_axis_out_tdata(a_dout), .m_axis_out_tvalid(a_ovld)
  );

  cic_decim_tail #(
    .DW(32), .RATE_DW(32), .CIC_R(2),
    .CIC_N(2), .CIC_M(1), .VARIABLE_RATE(1)
  ) dut_b (
    .clk(clk), .reset_n(rst_n),
    .s_axis_in_tdata(b_din), .s_axis_in_tvalid(b_vld),
    .s_axis_rate_tdata(b_rdat),
    .s_axis_rate_tvalid(b_rvld),
    .m_axis_out_tdata(b_dout), .m_axis_out_tvalid(b_ovld)
  );

  cic_decim_tail #(
    .DW(8), .RATE_DW(8), .CIC_R(1),
    .CIC_N(1), .CIC_M(2), .VARIABLE_RATE(0)
  ) dut_c (
    .clk(clk), .reset_n(rst_n),
    .s_axis_in_tdata(c_din), .s_axis_in_tvalid(c_vld),
    .s_axis_rate_tdata(c_rdat),
    .s_axis_rate_tvalid(c_rvld),
    .m_axis_out_tdata(c_dout), .m_axis_out_tvalid(c_ovld)
  );

  cic_decim_tail #(
    .DW(8), .RATE_DW(8), .CIC_R(1),
    .CIC_N(1), .CIC_M(1), .VARIABLE_RATE(0)
  ) dut_d (
    .clk(clk), .reset_n(rst_n),
    .s_axis_in_tdata(d_din), .s_axis_in_tvalid(d_vld),
    .s_axis_rate_tdata(d_rdat),
    .s_axis_rate_tvalid(d_rvld),
    .m_axis_out_tdata(d_dout), .m_axis_out_tvalid(d_ovld)
  );

  cic_decim_tail #(
    .DW(32), .RATE_DW(32), .CIC_R(10),
    .CIC_N(RN), .CIC_M(RM), .VARIABLE_RATE(1)
  ) dut_r (
    .clk(clk), .reset_n(rst_n),
    .s_axis_in_tdata(r_din), .s_axis_in_tvalid(r_vld),
    .s_axis_rate_tdata(r_rdat),
    .s_axis_rate_tvalid(r_rvld),
    .m_axis_out_tdata(r_dout), .m_axis_out_tvalid(r_ovld)
  );

  task automatic check(string name,
                       logic [63:0] got,
                       logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d",
               name, got, exp);
    end
  endtask

  // Output of N cascaded (1 - z^-M) filters, i.e. the
  // binomial expansion of (1 - z^-M)^N over decimated data.
  function automatic logic [31:0] comb_ref();
    logic [31:0] acc = 32'd0;
    int c = 1;
    int n = hist.size() - 1;
    for (int j = 0; j <= RN; j++) begin
      int k = n - j * RM;
      if (k >= 0) begin
        if (j % 2 == 1) acc = acc - 32'(c) * hist[k];
        else            acc = acc + 32'(c) * hist[k];
      end
      c = c * (RN - j) / (j + 1);
    end
    return acc;
  endfunction

  // Period bookkeeping: count samples since the period
  // started; the R-th one is kept.
  task automatic model_r();
    if (r_rvld) begin
      m_rate = (r_rdat == 32'd0) ? 1 : int'(r_rdat);
      m_seen = 0;
    end
    if (r_vld) begin
      m_seen++;
      if (m_seen >= m_rate) begin
        m_seen = 0;
        hist.push_back(r_din);
        exp_r.push_back('{cyc + 1 + RN, comb_ref()});
      end
    end
  endtask

  task automatic step();
    ev_t e;
    if (rst_n) model_r();
    @(posedge clk);
    #1;
    cyc++;
    if (a_ovld) qa.push_back('{cyc, a_dout});
    if (b_ovld) qb.push_back('{cyc, b_dout});
    if (r_ovld) begin
      r_outs++;
      if (exp_r.size() == 0) begin
        check("r_unexpected_strobe", 1, 0);
      end else begin
        e = exp_r.pop_front();
        check("r_cycle", 64'(cyc), 64'(e.cyc));
        check("r_data", r_dout, e.d);
      end
    end
  endtask

  task automatic idle_inputs();
    a_din = 0; a_vld = 0; a_rdat = 0; a_rvld = 0;
    b_din = 0; b_vld = 0; b_rdat = 0; b_rvld = 0;
    c_din = 0; c_vld = 0; c_rdat = 0; c_rvld = 0;
    d_din = 0; d_vld = 0; d_rdat = 0; d_rvld = 0;
    r_din = 0; r_vld = 0; r_rdat = 0; r_rvld = 0;
  endtask

  task automatic do_reset(string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_a_valid"}, a_ovld, 0);
    check({tag, "_a_data"}, a_dout, 0);
    check({tag, "_b_valid"}, b_ovld, 0);
    check({tag, "_b_data"}, b_dout, 0);
    check({tag, "_r_data"}, r_dout, 0);
    idle_inputs();
    qa.delete();
    qb.delete();
    exp_r.delete();
    hist.delete();
    m_rate = 10;
    m_seen = 0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int t3;
    int t4;
    logic [7:0] got;
    logic       gv;

    tbl[0] = '{1'b0, 8'd1, 8'd1};
    tbl[1] = '{1'b0, 8'd2, 8'd2};
    tbl[2] = '{1'b0, 8'd4, 8'd3};
    tbl[3] = '{1'b0, 8'd8, 8'd6};
    tbl[4] = '{1'b0, 8'd16, 8'd12};
    tbl[5] = '{1'b1, 8'd100, 8'd100};
    tbl[6] = '{1'b1, 8'd156, 8'd56};

    idle_inputs();
    #2;
    do_reset("reset");
    check("reset_c_valid", c_ovld, 0);
    check("reset_d_data", d_dout, 0);

    // Ramp at R=4, N=1; rate port toggled but ignored.
    t3 = 0;
    for (int i = 0; i < 16; i++) begin
      a_din = i; a_vld = 1; a_rvld = 1; a_rdat = 1;
      if (i == 3) t3 = cyc;
      step();
    end
    a_vld = 0; a_rvld = 0;
    repeat (4) step();
    check("ramp_count", qa.size(), 4);
    if (qa.size() == 4) begin
      check("ramp_first_cycle", 64'(qa[0].cyc), 64'(t3 + 2));
      check("ramp_period", 64'(qa[1].cyc - qa[0].cyc), 4);
      check("ramp_out0", qa[0].d, 3);
      check("ramp_out1", qa[1].d, 4);
      check("ramp_out3", qa[3].d, 4);
    end
    check("ramp_hold", a_dout, 4);

    // Table: R=1 single-comb vectors (M=2, and 8-bit wrap).
    foreach (tbl[i]) begin
      if (tbl[i].use_d) begin
        d_din = tbl[i].din; d_vld = 1;
      end else begin
        c_din = tbl[i].din; c_vld = 1;
      end
      step();
      c_vld = 0; d_vld = 0;
      step();
      got = tbl[i].use_d ? d_dout : c_dout;
      gv  = tbl[i].use_d ? d_ovld : c_ovld;
      check($sformatf("tbl%0d_valid", i), gv, 1);
      check($sformatf("tbl%0d_data", i), got, tbl[i].exp);
      step();
      gv = tbl[i].use_d ? d_ovld : c_ovld;
      check($sformatf("tbl%0d_pulse", i), gv, 0);
    end

    // Constant 5 through N=2 combs at R=2.
    for (int i = 0; i < 10; i++) begin
      b_din = 5; b_vld = 1;
      step();
    end
    b_vld = 0;
    repeat (5) step();
    check("const_count", qb.size(), 5);
    if (qb.size() == 5) begin
      check("const_out0", qb[0].d, 5);
      check("const_out1", qb[1].d, 32'hFFFF_FFFB);
      check("const_out2", qb[2].d, 0);
      check("const_out3", qb[3].d, 0);
    end

    // Variable rate: loads with and without same-cycle samples.
    do_reset("rst_var");
    b_rvld = 1; b_rdat = 4; b_vld = 0;
    step();
    b_rvld = 0;
    for (int i = 0; i < 3; i++) begin
      b_din = i * i; b_vld = 1;
      step();
    end
    b_din = 9; b_rvld = 1; b_rdat = 2;
    step();
    b_din = 16; b_rvld = 0; t4 = cyc;
    step();
    b_vld = 0; b_rvld = 1; b_rdat = 1;
    step();
    b_rvld = 0;
    for (int i = 5; i < 8; i++) begin
      b_din = i * i; b_vld = 1;
      step();
    end
    b_din = 64; b_rvld = 1; b_rdat = 0;
    step();
    b_vld = 0; b_rvld = 0;
    repeat (5) step();
    check("var_count", qb.size(), 5);
    if (qb.size() == 5) begin
      check("var_first_cycle", 64'(qb[0].cyc), 64'(t4 + 3));
      check("var_out0", qb[0].d, 16);
      check("var_out1", qb[1].d, 32'hFFFF_FFF9);
      check("var_out2", qb[2].d, 2);
      check("var_out3", qb[3].d, 2);
      check("var_out4", qb[4].d, 2);
    end

    // Gapped valid, reset mid-stream, then restart.
    do_reset("rst_gap");
    for (int i = 0; i < 6; i++) begin
      a_din = i; a_vld = 1;
      step();
      a_vld = 0;
      step();
      step();
    end
    check("gap_pre_count", qa.size(), 1);
    check("gap_pre_data", a_dout, 3);
    do_reset("rst_mid");
    for (int i = 0; i < 12; i++) begin
      a_din = i; a_vld = 1;
      step();
      a_vld = 0;
      step();
      step();
    end
    repeat (3) step();
    check("gap_count", qa.size(), 3);
    if (qa.size() == 3) begin
      check("gap_out0", qa[0].d, 3);
      check("gap_out1", qa[1].d, 4);
      check("gap_out2", qa[2].d, 4);
      check("gap_spacing", 64'(qa[1].cyc - qa[0].cyc), 12);
    end

    // Randomized run against the model (N=7, M=1).
    do_reset("rst_rand");
    r_outs = 0;
    for (int i = 0; i < 800; i++) begin
      r_vld  = ($urandom % 10) < 6;
      r_din  = $urandom;
      r_rvld = ($urandom % 32) == 0;
      r_rdat = $urandom_range(0, 5);
      step();
    end
    r_vld = 0; r_rvld = 0;
    repeat (RN + 4) step();
    check("rand_pending", exp_r.size(), 0);
    check("rand_enough_outputs", r_outs > 20, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
